// File: rtl/spi_slave_fd_if.sv
// rtl/spi_slave_fd_if.sv - SPI pin and parallel word bundle for spi_slave_fd
//
// SPI pins    : SCK, MOSI, CSEL (active-low) from the master; MISO back to it.
// Mode/length : cpol, cpha, byte_count, sampled by the slave at frame start.
// Transmit    : tx_data/tx_load in, tx_ready out (one-deep pending word).
// Receive     : rx_data/rx_valid out, frame_err and tx_underrun event pulses.
// Status      : busy.
// Modports    : slave (the SPI slave block), master (whatever drives it).
interface spi_slave_fd_if #(
    parameter int MAX_BYTES = 8,
    parameter int DATA_W    = 8 * MAX_BYTES
);
    logic              SCK;
    logic              MOSI;
    logic              CSEL;
    logic              MISO;
    logic              cpol;
    logic              cpha;
    logic [3:0]        byte_count;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  SCK, MOSI, CSEL, cpol, cpha, byte_count, tx_data, tx_load,
        output MISO, tx_ready, rx_data, rx_valid, frame_err, tx_underrun, busy
    );

    modport master (
        output SCK, MOSI, CSEL, cpol, cpha, byte_count, tx_data, tx_load,
        input  MISO, tx_ready, rx_data, rx_valid, frame_err, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_fd.sv
// rtl/spi_slave_fd.sv - full-duplex SPI slave with per-frame mode and length
//
// CLK  : system clock, at least 8x SCK.
// RST  : synchronous, active-high.
// bus  : spi_slave_fd_if.slave
//        SCK/MOSI/CSEL are asynchronous and synchronised internally.
//        MISO is forced to 0 by raw CSEL=1.
//        tx_load (with tx_ready=1) fills a one-deep pending word, consumed at
//        frame start; rx_data/rx_valid present each complete frame;
//        frame_err and tx_underrun are one-cycle pulses; busy is high outside IDLE.
module spi_slave_fd #(
    parameter int MAX_BYTES = 8,
    parameter int DATA_W    = 8 * MAX_BYTES
) (
    input  logic          CLK,
    input  logic          RST,
    spi_slave_fd_if.slave bus
);
    localparam int CNT_W = $clog2(8 * MAX_BYTES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Synchronisers: [0],[1] are the 2-FF synchroniser, [2] is the history
    // stage used only for edge detection.
    logic [2:0] sck_s;
    logic [2:0] csel_s;
    logic [1:0] mosi_s;

    logic [1:0] settle_q;
    logic       armed_q;

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] pending_q;
    logic              tx_ready_q;
    logic              miso_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              underrun_q;

    logic              sck_rise;
    logic              sck_fall;
    logic              csel_fall;
    logic              csel_rise;
    logic              mosi_bit;
    logic              sample_edge;
    logic              shift_edge;
    logic              frame_start;
    logic [3:0]        eff_bytes;
    logic [CNT_W-1:0]  n_start;
    logic [7:0]        align_sh;
    logic [DATA_W-1:0] start_word;
    logic [DATA_W-1:0] start_aligned;
    logic [DATA_W-1:0] rx_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_s  <= 3'b000;
            csel_s <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], bus.SCK};
            csel_s <= {csel_s[1:0], bus.CSEL};
            mosi_s <= {mosi_s[0], bus.MOSI};
        end
    end

    assign sck_rise  =  sck_s[1]  & ~sck_s[2];
    assign sck_fall  = ~sck_s[1]  &  sck_s[2];
    assign csel_fall = ~csel_s[1] &  csel_s[2];
    assign csel_rise =  csel_s[1] & ~csel_s[2];
    assign mosi_bit  =  mosi_s[1];

    // The synchroniser resets to "CSEL high", so a CSEL already held low at
    // reset release looks like a falling edge. Frames are only accepted once
    // the real CSEL level has flushed through the flops and been seen high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd3 && csel_s[2]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign frame_start = (state_q == S_IDLE) && armed_q && csel_fall;
    assign sample_edge = (cpol_q == cpha_q) ? sck_rise : sck_fall;
    assign shift_edge  = (cpol_q == cpha_q) ? sck_fall : sck_rise;

    always_comb begin
        eff_bytes = bus.byte_count;
        if (bus.byte_count == 4'd0 || bus.byte_count > 4'(MAX_BYTES)) begin
            eff_bytes = 4'(MAX_BYTES);
        end
        n_start  = CNT_W'({eff_bytes, 3'b000});
        align_sh = 8'(DATA_W) - 8'(n_start);

        // A word loaded in the frame-start cycle itself goes straight out.
        if (!tx_ready_q) begin
            start_word = pending_q;
        end else if (bus.tx_load) begin
            start_word = bus.tx_data;
        end else begin
            start_word = '0;
        end

        // The shadow is kept MSB-aligned so the next bit out is always the top bit.
        start_aligned = start_word << align_sh;
        rx_next       = {rx_sh_q[DATA_W-2:0], mosi_bit};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            pending_q   <= '0;
            tx_ready_q  <= 1'b1;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;

            if (frame_start) begin
                tx_ready_q <= 1'b1;
                underrun_q <= tx_ready_q & ~bus.tx_load;
            end else if (bus.tx_load && tx_ready_q) begin
                pending_q  <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (frame_start) begin
                        state_q <= S_SHIFT;
                        cpol_q  <= bus.cpol;
                        cpha_q  <= bus.cpha;
                        cnt_q   <= n_start;
                        rx_sh_q <= '0;
                        if (bus.cpha) begin
                            tx_sh_q <= start_aligned;
                        end else begin
                            // cpha=0: first bit must be on MISO before the first SCK edge.
                            miso_q  <= start_aligned[DATA_W-1];
                            tx_sh_q <= start_aligned << 1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sample_edge && cnt_q == CNT_W'(1)) begin
                        // Last bit wins over a simultaneous CSEL rise.
                        rx_sh_q    <= rx_next;
                        rx_data_q  <= rx_next;
                        rx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        miso_q     <= 1'b0;
                        state_q    <= csel_rise ? S_IDLE : S_DONE;
                    end else if (csel_rise) begin
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        if (sample_edge) begin
                            rx_sh_q <= rx_next;
                            cnt_q   <= cnt_q - CNT_W'(1);
                        end
                        if (shift_edge) begin
                            miso_q  <= tx_sh_q[DATA_W-1];
                            tx_sh_q <= tx_sh_q << 1;
                        end
                    end
                end
                S_DONE: begin
                    miso_q <= 1'b0;
                    if (csel_rise) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    miso_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.MISO        = bus.CSEL ? 1'b0 : miso_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_slave_fd.sv
// tb/tb_spi_slave_fd.sv - scoreboard bench for spi_slave_fd
module tb_spi_slave_fd;
    localparam int MAXB = 8;
    localparam int DW   = 64;
    localparam int HALF = 8;
    localparam int K_RX  = 0;
    localparam int K_ERR = 1;
    localparam int K_UND = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic mosi_drv;
    logic loop_en;
    logic [127:0] got;

    always #5 CLK = ~CLK;

    spi_slave_fd_if #(.MAX_BYTES(MAXB), .DATA_W(DW)) bus ();

    spi_slave_fd #(.MAX_BYTES(MAXB), .DATA_W(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    assign bus.MOSI = loop_en ? bus.MISO : mosi_drv;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input logic [63:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_event(input int kind, input logic [63:0] data, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: event seen with kind %0d, none expected", name, kind);
        end else begin
            e = sb.pop_front();
            check({name, " kind"}, 128'(kind), 128'(e.kind));
            if (kind == K_RX && e.kind == K_RX) begin
                check({name, " data"}, 128'(data), 128'(e.data));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.rx_valid)    sb_event(K_RX,  bus.rx_data, "rx_valid");
            if (bus.frame_err)   sb_event(K_ERR, 64'd0,       "frame_err");
            if (bus.tx_underrun) sb_event(K_UND, 64'd0,       "tx_underrun");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load_tx(input logic [63:0] d);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic spi_frame(input bit cp, input bit ch, input logic [3:0] bc, input int nbits,
                             input logic [127:0] mo, input int abort_at, input bit start_load,
                             input logic [63:0] sl_data, output logic [127:0] g);
        g = '0;
        bus.cpol       = cp;
        bus.cpha       = ch;
        bus.byte_count = bc;
        bus.SCK        = cp;
        tick(4);
        if (!ch) mosi_drv = mo[nbits-1];
        bus.CSEL = 1'b0;
        if (start_load) begin
            tick(2);
            bus.tx_data = sl_data;
            bus.tx_load = 1'b1;
            tick(1);
            bus.tx_load = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) break;
            if (i == 1) check("busy in frame", 128'(bus.busy), 128'd1);
            if (!ch) begin
                bus.SCK = ~bus.SCK;
                g = {g[126:0], bus.MISO};
                tick(HALF);
                bus.SCK = ~bus.SCK;
                if (i + 1 < nbits) mosi_drv = mo[nbits-2-i];
                tick(HALF);
            end else begin
                bus.SCK = ~bus.SCK;
                mosi_drv = mo[nbits-1-i];
                tick(HALF);
                bus.SCK = ~bus.SCK;
                g = {g[126:0], bus.MISO};
                tick(HALF);
            end
        end
        bus.CSEL = 1'b1;
        tick(8);
    endtask

    initial begin
        bus.SCK = 1'b0;
        bus.CSEL = 1'b1;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.byte_count = 4'd2;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        mosi_drv = 1'b0;
        loop_en = 1'b0;

        RST = 1'b1;
        tick(4);
        check("reset tx_ready", 128'(bus.tx_ready), 128'd1);
        check("reset busy", 128'(bus.busy), 128'd0);
        check("reset rx_data", 128'(bus.rx_data), 128'd0);
        check("reset pulses", 128'({bus.rx_valid, bus.frame_err, bus.tx_underrun}), 128'd0);
        check("reset miso", 128'(bus.MISO), 128'd0);
        RST = 1'b0;
        tick(10);

        // Mode 0, two bytes; second load must be ignored while one is pending.
        load_tx(64'hA55A);
        check("tx_ready after load", 128'(bus.tx_ready), 128'd0);
        load_tx(64'hFFFF);
        push_exp(K_RX, 64'h1234);
        spi_frame(1'b0, 1'b0, 4'd2, 16, 128'h1234, -1, 1'b0, 64'd0, got);
        check("mode0 miso", got, 128'hA55A);
        check("tx_ready after start", 128'(bus.tx_ready), 128'd1);

        for (int m = 1; m < 4; m++) begin
            load_tx(64'h81);
            push_exp(K_RX, 64'h3C);
            spi_frame(m[1], m[0], 4'd1, 8, 128'h3C, -1, 1'b0, 64'd0, got);
            check($sformatf("mode%0d miso", m), got, 128'h81);
        end

        // Full-length loopback.
        load_tx(64'h0123456789ABCDEF);
        push_exp(K_RX, 64'h0123456789ABCDEF);
        loop_en = 1'b1;
        spi_frame(1'b0, 1'b0, 4'd8, 64, 128'd0, -1, 1'b0, 64'd0, got);
        loop_en = 1'b0;
        check("loopback miso", got, 128'h0123456789ABCDEF);

        // byte_count 0 and 12 both mean MAX_BYTES.
        load_tx(64'hFEDCBA9876543210);
        push_exp(K_RX, 64'h1122334455667788);
        spi_frame(1'b0, 1'b1, 4'd0, 64, 128'h1122334455667788, -1, 1'b0, 64'd0, got);
        check("bc0 miso", got, 128'hFEDCBA9876543210);
        load_tx(64'h8000000000000001);
        push_exp(K_RX, 64'hAAAA5555AAAA5555);
        spi_frame(1'b1, 1'b0, 4'd12, 64, 128'hAAAA5555AAAA5555, -1, 1'b0, 64'd0, got);
        check("bc12 miso", got, 128'h8000000000000001);

        // Abort after 11 of 16 bits.
        load_tx(64'hBEEF);
        push_exp(K_ERR, 64'd0);
        spi_frame(1'b0, 1'b0, 4'd2, 16, 128'hCAFE, 11, 1'b0, 64'd0, got);
        check("abort partial miso", got, 128'h5F7);
        check("rx_data kept after abort", 128'(bus.rx_data), 128'hAAAA5555AAAA5555);

        // No word loaded.
        push_exp(K_UND, 64'd0);
        push_exp(K_RX, 64'h5A);
        spi_frame(1'b0, 1'b0, 4'd1, 8, 128'h5A, -1, 1'b0, 64'd0, got);
        check("underrun miso", got, 128'd0);

        // Word loaded in the frame-start cycle.
        push_exp(K_RX, 64'h99);
        spi_frame(1'b1, 1'b1, 4'd1, 8, 128'h99, -1, 1'b1, 64'hC3, got);
        check("start-load miso", got, 128'hC3);
        check("start-load tx_ready", 128'(bus.tx_ready), 128'd1);

        // Reset in the middle of a frame with CSEL held low.
        load_tx(64'h77);
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.byte_count = 4'd1;
        bus.SCK = 1'b0;
        tick(4);
        bus.CSEL = 1'b0;
        tick(HALF);
        for (int i = 0; i < 4; i++) begin
            bus.SCK = ~bus.SCK;
            tick(HALF);
        end
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        check("mid reset tx_ready", 128'(bus.tx_ready), 128'd1);
        check("mid reset busy", 128'(bus.busy), 128'd0);
        check("mid reset rx_data", 128'(bus.rx_data), 128'd0);
        check("mid reset miso", 128'(bus.MISO), 128'd0);
        for (int i = 0; i < 16; i++) begin
            bus.SCK = ~bus.SCK;
            mosi_drv = i[0];
            tick(HALF);
        end
        check("no frame while CSEL stays low", 128'(bus.busy), 128'd0);
        bus.CSEL = 1'b1;
        tick(8);
        load_tx(64'h5E);
        push_exp(K_RX, 64'hE5);
        spi_frame(1'b0, 1'b0, 4'd1, 8, 128'hE5, -1, 1'b0, 64'd0, got);
        check("post-reset miso", got, 128'h5E);

        tick(20);
        check("scoreboard drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_fd.md
SPI_SLAVE_FD -- requirements
Module: spi_slave_fd

Interface
REQ-001 Parameter MAX_BYTES, default 8: maximum frame length in bytes, legal range 1..15.
REQ-002 Parameter DATA_W, default 8*MAX_BYTES: width of the tx and rx data words.
REQ-003 CLK  in  1  system clock; all logic is synchronous to it; SCK is no faster than CLK/8.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 SCK  in  1  SPI clock, asynchronous to CLK.
REQ-006 MOSI  in  1  serial data in, asynchronous to CLK.
REQ-007 CSEL  in  1  chip select, active-low, asynchronous to CLK.
REQ-008 MISO  out  1  serial data out; 0 whenever CSEL=1 (combinational on raw CSEL).
REQ-009 cpol, cpha  in  1 each  SPI mode; captured at frame start and held for the whole frame.
REQ-010 byte_count  in  4  frame length in bytes; captured at frame start; 0 or >MAX_BYTES is treated as MAX_BYTES.
REQ-011 tx_data  in  DATA_W  transmit word, right-aligned.
REQ-012 tx_load  in  1  single-cycle strobe; accepted only while tx_ready=1.
REQ-013 tx_ready  out  1  1 when no transmit word is pending.
REQ-014 rx_data  out  DATA_W  last complete received frame, right-aligned, upper bits zero.
REQ-015 rx_valid  out  1  one-cycle pulse marking a new rx_data.
REQ-016 frame_err  out  1  one-cycle pulse: CSEL rose before the last bit was sampled.
REQ-017 tx_underrun  out  1  one-cycle pulse: a frame started with no pending tx word.
REQ-018 busy  out  1  1 in SHIFT and DONE.

Function
REQ-019 SCK, CSEL and MOSI each pass through a 2-FF synchroniser; edges are detected from the 2nd and 3rd flop stages.
REQ-020 States: IDLE, SHIFT, DONE.
REQ-021 IDLE -> SHIFT on a synchronised CSEL falling edge only; a CSEL level never starts a frame.
REQ-022 Frame bit count is N = 8*byte_count; the bit counter is $clog2(8*MAX_BYTES+1) bits wide and loads N at frame start.
REQ-023 Sample edge is rising when cpol==cpha, otherwise falling; the shift edge is the opposite edge.
REQ-024 Data is MSB first: bit N-1 of the transmit shadow is sent first, and the first received bit lands in rx bit N-1.
REQ-025 cpha=0: MISO presents bit N-1 from the frame-start cycle, then advances one bit per shift edge.
REQ-025a cpha=1: MISO presents bit N-1 on the first shift edge; MISO holds its value between edges.
REQ-026 Each sample edge in SHIFT shifts the synchronised MOSI in and decrements the counter.
REQ-027 SHIFT -> DONE when the Nth sample completes; on the next cycle rx_data updates and rx_valid pulses.
REQ-028 Latency from final sample-edge detect to rx_valid is 1 CLK.
REQ-029 rx_data holds its value until the next valid frame completes.
REQ-030 In DONE, further SCK edges are ignored and MISO drives 0; DONE -> IDLE on CSEL rising edge.
REQ-031 CSEL rising edge in SHIFT: pulse frame_err, no rx_valid, rx_data unchanged, go to IDLE.
REQ-032 tx_load with tx_ready=1 copies tx_data to the pending register and clears tx_ready.
REQ-033 At frame start, the pending word moves to the transmit shadow and tx_ready returns to 1.
REQ-034 Frame start with nothing pending: shadow loads all-zero and tx_underrun pulses.
REQ-035 tx_load in the same cycle as a frame-start detect is used for that frame, with no underrun.
REQ-036 tx_load while tx_ready=0 is ignored.

Reset
REQ-037 RST forces IDLE, counter 0, tx_ready=1, and rx_data, shadow, pending, rx_valid, frame_err, tx_underrun and busy all to 0.
REQ-038 Synchroniser flops reset to CSEL=1 and SCK=0 history, so a frame in progress when RST releases is ignored until CSEL goes high again.

Verification
REQ-039 Mode 0, byte_count=2, tx_load 0xA55A, master sends 0x1234 -> MISO bits A55A MSB-first, rx_data=0x1234, one rx_valid, tx_ready=1 after start.
REQ-040 Modes 1, 2 and 3, byte_count=1, tx 0x81, rx 0x3C -> correct bits on each mode's edges, rx_data=0x3C.
REQ-041 byte_count=8, tx 0x0123456789ABCDEF, loopback MOSI=MISO -> rx_data=0x0123456789ABCDEF.
REQ-042 CSEL raised after 11 of 16 bits -> frame_err pulse, no rx_valid, rx_data keeps its previous value.
REQ-043 Frame with no tx_load -> tx_underrun pulse, MISO all 0; tx_load in the start cycle -> word sent, no underrun.
REQ-044 RST asserted mid-frame with CSEL held low -> outputs at reset values, no frame until CSEL goes high then low again.
